// File: rtl/clock_gen_multi.sv
// clock_gen_multi: NUM_CH independent integer clock dividers driven by one
// input clock. Each channel produces a registered 50%-ish divided clock and a
// one-cycle tick on the last cycle of its period. Divisors are reprogrammed
// through a valid/ready port; a new divisor is staged in a shadow register
// and only takes effect on a period boundary, so a divided clock never shows
// a runt or stretched pulse.
module clock_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  // Per-channel state.
  logic [DIV_W-1:0]  div_q    [NUM_CH];  // active divisor D
  logic [DIV_W-1:0]  cnt_q    [NUM_CH];  // position in period, 0..D-1
  logic [DIV_W-1:0]  shadow_q [NUM_CH];  // staged divisor, valid while pending
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] clk_q;
  logic              cfg_err_q;

  // Next-state values.
  logic [DIV_W-1:0]  div_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] restart;
  logic [NUM_CH-1:0] apply;

  // Configuration port decode.
  logic [NUM_CH-1:0] ch_sel;
  logic              ch_in_range;
  logic              div_legal;
  logic              accept;
  logic              accept_good;
  logic              accept_bad;

  // One-hot decode of the target channel; an out-of-range channel selects none.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    ch_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = (32'(cfg_ch) == i);
    end
  end

  assign ch_in_range = |ch_sel;
  assign div_legal   = (cfg_div >= TWO);

  // A channel with a write in flight blocks further writes to it; a
  // nonexistent channel never blocks, so its write is taken and rejected.
  assign cfg_ready   = ~|(pending_q & ch_sel);
  assign accept      = cfg_valid & cfg_ready;
  assign accept_good = accept & ch_in_range & div_legal;
  assign accept_bad  = accept & ~(ch_in_range & div_legal);

  // Per-channel counter, divisor swap and clock-level computation.
  always_comb begin
    wrap      = '0;
    restart   = '0;
    apply     = '0;
    pending_d = pending_q;
    clk_d     = '0;
    div_d     = div_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      // Last cycle of an enabled period: the edge ending it is the only
      // point where an enabled channel may change its divisor.
      wrap[i]    = en[i] && (cnt_q[i] == (div_q[i] - ONE));
      // Any of these return the counter to 0 on the coming edge.
      restart[i] = sync_rst || !en[i] || wrap[i];
      // A staged divisor is taken only at a restart, so the period in
      // progress always completes with its original length.
      apply[i]   = pending_q[i] && restart[i];

      div_d[i]   = apply[i] ? shadow_q[i] : div_q[i];
      cnt_d[i]   = restart[i] ? '0 : (cnt_q[i] + ONE);
      // Register the level the output must show for the next count so that
      // clk_out is a flop yet tracks cnt/D in the same cycle.
      clk_d[i]   = (cnt_d[i] >= (div_d[i] >> 1));

      // A write landing on the same edge as a swap is a fresh request and
      // stays pending for the following boundary.
      pending_d[i] = (pending_q[i] && !apply[i]) || (accept_good && ch_sel[i]);
    end
  end

  // Control and counter state, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(2 * (i + 1));
        cnt_q[i] <= '0;
      end
      pending_q <= '0;
      clk_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pending_q <= pending_d;
      clk_q     <= clk_d;
      cfg_err_q <= accept_bad;
    end
  end

  // Shadow divisors capture accepted legal writes.
  always_ff @(posedge clock) begin
    // NOTE: the shadow registers are deliberately left without reset; their
    // contents are only ever used while the matching pending bit is set, and
    // that bit is cleared by reset.
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept_good && ch_sel[i]) begin
        shadow_q[i] <= cfg_div;
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = wrap;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clock_gen_multi.sv
// Directed bench for clock_gen_multi with default parameters (4 channels,
// 8-bit divisors). Inputs are driven and outputs sampled on the falling edge.
module tb_clock_gen_multi;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] en = '0;
  logic       sync_rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_err;
  logic [3:0] clk_out;
  logic [3:0] tick;

  int pass_cnt  = 0;
  int total_cnt = 0;

  clock_gen_multi #(.NUM_CH(4), .DIV_W(8), .CH_W(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .sync_rst (sync_rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clock = ~clock;

  // Expected level/tick for count c of a divide-by-d period.
  function automatic logic exp_clk(input int c, input int d);
    return c >= (d / 2);
  endfunction

  function automatic logic exp_tick(input int c, input int d);
    return c == (d - 1);
  endfunction

  // Reset divisors 2,4,6,8, all enabled since k=0, sampled after edge k.
  function automatic logic [7:0] def_outs(input int k);
    logic [3:0] c_v;
    logic [3:0] t_v;
    for (int i = 0; i < 4; i++) begin
      c_v[i] = exp_clk(k % (2 * (i + 1)), 2 * (i + 1));
      t_v[i] = exp_tick(k % (2 * (i + 1)), 2 * (i + 1));
    end
    return {c_v, t_v};
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    en = '0;
    sync_rst = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    total_cnt++;
    if ({clk_out, tick, cfg_err, cfg_ready} !== 10'b0000_0000_0_1)
      $display("FAIL reset_state: got clk=%b tick=%b err=%b rdy=%b required 0000 0000 0 1",
               clk_out, tick, cfg_err, cfg_ready);
    else pass_cnt++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total_cnt++;
    if ({clk_out, tick} !== 8'h00)
      $display("FAIL reset_disabled_idle: got %b required 00000000", {clk_out, tick});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    apply_reset();
    en = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      total_cnt++;
      if ({clk_out, tick} !== def_outs(k))
        $display("FAIL basic k=%0d: got %b required %b", k, {clk_out, tick}, def_outs(k));
      else pass_cnt++;
    end
  endtask

  task automatic test_reconfig();
    int highs;
    highs = 0;
    apply_reset();
    en = 4'hF;
    @(negedge clock);  // k=1, ch1 mid-period
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    #1;
    total_cnt++;
    if (cfg_ready !== 1'b1) $display("FAIL reconfig_ready_before: got %b required 1", cfg_ready);
    else pass_cnt++;
    @(negedge clock);  // k=2
    cfg_valid = 1'b0;
    total_cnt++;
    if ({cfg_ready, clk_out[1], cfg_err} !== 3'b010)
      $display("FAIL reconfig_k2: got rdy/clk1/err=%b required 010", {cfg_ready, clk_out[1], cfg_err});
    else pass_cnt++;
    @(negedge clock);  // k=3, old /4 period ends
    total_cnt++;
    if ({cfg_ready, clk_out[1], tick[1]} !== 3'b011)
      $display("FAIL reconfig_k3: got rdy/clk1/tick1=%b required 011", {cfg_ready, clk_out[1], tick[1]});
    else pass_cnt++;
    for (int k = 4; k <= 13; k++) begin
      @(negedge clock);
      if (k <= 8) highs += int'(clk_out[1]);
      total_cnt++;
      if ({clk_out[1], tick[1]} !== {exp_clk((k - 4) % 5, 5), exp_tick((k - 4) % 5, 5)})
        $display("FAIL reconfig_div5 k=%0d: got %b required %b", k, {clk_out[1], tick[1]},
                 {exp_clk((k - 4) % 5, 5), exp_tick((k - 4) % 5, 5)});
      else pass_cnt++;
    end
    total_cnt++;
    if (highs != 3) $display("FAIL reconfig_high_time: got %0d required 3", highs);
    else pass_cnt++;
    total_cnt++;
    if (cfg_ready !== 1'b1) $display("FAIL reconfig_ready_after: got %b required 1", cfg_ready);
    else pass_cnt++;
  endtask

  task automatic test_cfg_err();
    apply_reset();
    en = 4'hF;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
    @(negedge clock);  // k=1
    cfg_valid = 1'b0;
    #1;
    total_cnt++;
    if ({cfg_err, cfg_ready} !== 2'b11)
      $display("FAIL cfg_err_div1: got err/rdy=%b required 11", {cfg_err, cfg_ready});
    else pass_cnt++;
    @(negedge clock);  // k=2
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL cfg_err_div1_end: got %b required 0", cfg_err);
    else pass_cnt++;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0;
    #1;
    total_cnt++;
    if (cfg_ready !== 1'b1) $display("FAIL cfg_err_ready_ch3: got %b required 1", cfg_ready);
    else pass_cnt++;
    @(negedge clock);  // k=3
    cfg_valid = 1'b0;
    #1;
    total_cnt++;
    if ({cfg_err, cfg_ready} !== 2'b11)
      $display("FAIL cfg_err_div0: got err/rdy=%b required 11", {cfg_err, cfg_ready});
    else pass_cnt++;
    @(negedge clock);  // k=4
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL cfg_err_div0_end: got %b required 0", cfg_err);
    else pass_cnt++;
    for (int k = 5; k <= 20; k++) begin
      @(negedge clock);
      total_cnt++;
      if ({clk_out, tick} !== def_outs(k))
        $display("FAIL cfg_err_divs k=%0d: got %b required %b", k, {clk_out, tick}, def_outs(k));
      else pass_cnt++;
    end
  endtask

  task automatic test_disabled();
    apply_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd3;
    @(negedge clock);  // accepted
    cfg_valid = 1'b0;
    #1;
    total_cnt++;
    if (cfg_ready !== 1'b0) $display("FAIL disabled_pending: got %b required 0", cfg_ready);
    else pass_cnt++;
    @(negedge clock);  // applied while disabled
    total_cnt++;
    if ({cfg_ready, clk_out, tick} !== 9'b1_0000_0000)
      $display("FAIL disabled_applied: got %b required 100000000", {cfg_ready, clk_out, tick});
    else pass_cnt++;
    en = 4'b1000;
    for (int m = 1; m <= 9; m++) begin
      @(negedge clock);
      total_cnt++;
      if ({clk_out, tick} !== {exp_clk(m % 3, 3), 3'b000, exp_tick(m % 3, 3), 3'b000})
        $display("FAIL disabled_div3 m=%0d: got %b required %b", m, {clk_out, tick},
                 {exp_clk(m % 3, 3), 3'b000, exp_tick(m % 3, 3), 3'b000});
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_edge();
    int c;
    int d;
    apply_reset();
    en = 4'hF;
    repeat (5) @(negedge clock);  // k=5, ch2 on its last cycle
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
    #1;
    total_cnt++;
    if ({tick[2], cfg_ready} !== 2'b11)
      $display("FAIL wrap_write_cycle: got tick2/rdy=%b required 11", {tick[2], cfg_ready});
    else pass_cnt++;
    @(negedge clock);  // k=6
    cfg_valid = 1'b0;
    for (int k = 6; k <= 20; k++) begin
      if (k > 6) @(negedge clock);
      d = (k < 12) ? 6 : 3;
      c = (k < 12) ? (k - 6) % 6 : (k - 12) % 3;
      total_cnt++;
      if ({clk_out[2], tick[2]} !== {exp_clk(c, d), exp_tick(c, d)})
        $display("FAIL wrap_ch2 k=%0d: got %b required %b", k, {clk_out[2], tick[2]},
                 {exp_clk(c, d), exp_tick(c, d)});
      else pass_cnt++;
      if (k == 11 || k == 12) begin
        total_cnt++;
        if (cfg_ready !== (k == 12))
          $display("FAIL wrap_ready k=%0d: got %b required %b", k, cfg_ready, (k == 12));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_sync_rst();
    logic [3:0] ec;
    logic [3:0] et;
    int d1;
    int c1;
    apply_reset();
    en = 4'hF;
    repeat (4) @(negedge clock);  // k=4
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd4;
    @(negedge clock);  // k=5, ch3 pending
    total_cnt++;
    if (clk_out !== 4'b1101) $display("FAIL sync_phase: got %b required 1101", clk_out);
    else pass_cnt++;
    cfg_ch = 2'd1; cfg_div = 8'd3; sync_rst = 1'b1;
    #1;
    total_cnt++;
    if (cfg_ready !== 1'b1) $display("FAIL sync_ready_ch1: got %b required 1", cfg_ready);
    else pass_cnt++;
    @(negedge clock);  // j=0
    cfg_valid = 1'b0; sync_rst = 1'b0;
    #1;
    total_cnt++;
    if ({clk_out, tick, cfg_ready} !== 9'b0000_0000_0)
      $display("FAIL sync_aligned: got %b required 000000000", {clk_out, tick, cfg_ready});
    else pass_cnt++;
    cfg_ch = 2'd3;
    #1;
    total_cnt++;
    if (cfg_ready !== 1'b1) $display("FAIL sync_ch3_applied: got %b required 1", cfg_ready);
    else pass_cnt++;
    cfg_ch = 2'd1;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clock);
      d1 = (j < 4) ? 4 : 3;
      c1 = (j < 4) ? j : (j - 4) % 3;
      ec = {exp_clk(j % 4, 4), exp_clk(j % 6, 6), exp_clk(c1, d1), exp_clk(j % 2, 2)};
      et = {exp_tick(j % 4, 4), exp_tick(j % 6, 6), exp_tick(c1, d1), exp_tick(j % 2, 2)};
      total_cnt++;
      if ({clk_out, tick} !== {ec, et})
        $display("FAIL sync_run j=%0d: got %b required %b", j, {clk_out, tick}, {ec, et});
      else pass_cnt++;
      if (j == 3 || j == 4) begin
        total_cnt++;
        if (cfg_ready !== (j == 4))
          $display("FAIL sync_ch1_pending j=%0d: got %b required %b", j, cfg_ready, (j == 4));
        else pass_cnt++;
      end
      if (j == 11) begin
        total_cnt++;
        if ((tick & 4'b1101) !== 4'b1101)
          $display("FAIL sync_common_tick: got %b required 1x01", tick);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    en = 4'hF;
    repeat (2) @(negedge clock);  // k=2
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd9;
    @(negedge clock);  // k=3
    cfg_ch = 2'd3; cfg_div = 8'd5;
    @(negedge clock);  // k=4
    cfg_valid = 1'b0; cfg_ch = 2'd2;
    #1;
    total_cnt++;
    if ({cfg_ready, clk_out} !== 5'b0_1100)
      $display("FAIL async_pre: got rdy/clk=%b required 01100", {cfg_ready, clk_out});
    else pass_cnt++;
    #1 reset = 1'b1;
    #1;
    total_cnt++;
    if ({clk_out, tick, cfg_err, cfg_ready} !== 10'b0000_0000_0_1)
      $display("FAIL async_reset_now: got %b required 0000000001", {clk_out, tick, cfg_err, cfg_ready});
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      total_cnt++;
      if ({clk_out, tick} !== def_outs(k))
        $display("FAIL async_divs k=%0d: got %b required %b", k, {clk_out, tick}, def_outs(k));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reconfig();
    test_cfg_err();
    test_disabled();
    test_wrap_edge();
    test_sync_rst();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clock_gen_multi.md
CLOCK_GEN_MULTI -- requirements
Module: clock_gen_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent divided-clock channels (1..16).
REQ-002 The block SHALL have parameter DIV_W, default 8, giving the width of each divisor (4..16).
REQ-003 The block SHALL have parameter CH_W, default 2, giving the channel-select width; CH_W SHALL be max(1, ceil(log2(NUM_CH))).
REQ-004 The block SHALL have port: clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port: en  in  NUM_CH  per-channel run enable.
REQ-007 The block SHALL have port: sync_rst  in  1  single-cycle pulse that phase-aligns all channels.
REQ-008 The block SHALL have port: cfg_valid  in  1  divisor write request.
REQ-009 The block SHALL have port: cfg_ready  out  1  write can be accepted this cycle.
REQ-010 The block SHALL have port: cfg_ch  in  CH_W  target channel.
REQ-011 The block SHALL have port: cfg_div  in  DIV_W  requested divisor D.
REQ-012 The block SHALL have port: cfg_err  out  1  one-cycle pulse flagging a rejected write.
REQ-013 The block SHALL have port: clk_out  out  NUM_CH  divided clocks, registered, glitch-free.
REQ-014 The block SHALL have port: tick  out  NUM_CH  one-cycle pulse on the last cycle of each channel period.

Function
REQ-015 Each channel i SHALL hold an active divisor D[i], a counter cnt[i] in 0..D[i]-1, a pending flag and a shadow divisor.
REQ-016 When en[i]=1, cnt[i] SHALL increment every cycle and wrap from D[i]-1 to 0.
REQ-017 clk_out[i] SHALL be 1 exactly in cycles where cnt[i] >= floor(D[i]/2); it SHALL be driven from a flop; period = D[i] cycles; high time = D[i]-floor(D[i]/2).
REQ-018 tick[i] SHALL be 1 exactly in cycles where cnt[i] = D[i]-1 and en[i]=1.
REQ-019 When en[i]=0, cnt[i] SHALL be held at 0, clk_out[i]=0 and tick[i]=0; on re-enable, counting SHALL resume from 0.
REQ-020 A write SHALL be accepted on a rising edge where cfg_valid=1 and cfg_ready=1.
REQ-021 cfg_ready SHALL be the inverse of pending[cfg_ch] (0 if cfg_ch >= NUM_CH is never blocking: cfg_ready=1).
REQ-022 An accepted write with cfg_div < 2 or cfg_ch >= NUM_CH SHALL change no state and SHALL pulse cfg_err for the following cycle.
REQ-023 Otherwise, an accepted write SHALL load the shadow divisor and set pending[cfg_ch]; cfg_err SHALL stay 0.
REQ-024 An enabled channel SHALL apply a pending divisor only on the edge where cnt wraps (cnt=D-1 -> 0), then clear pending; no runt or stretched pulse SHALL occur.
REQ-025 A disabled channel SHALL apply a pending divisor on the edge following acceptance.
REQ-026 A write accepted on the same edge as that channel's wrap SHALL become pending and SHALL apply at the next wrap, not the current one.
REQ-027 sync_rst=1 SHALL force cnt of all channels to 0 on that edge and SHALL apply any divisor pending before that edge.
REQ-028 A write accepted on a sync_rst edge SHALL remain pending, subject to REQ-024/REQ-025.
REQ-029 Divisor arithmetic SHALL be unsigned DIV_W bits; D = 2^DIV_W-1 SHALL be legal.

Reset
REQ-030 When reset=1, cnt=0 for all channels SHALL hold asynchronously.
REQ-031 When reset=1, clk_out=0 and tick=0 SHALL hold asynchronously.
REQ-032 When reset=1, pending=0 and cfg_err=0 SHALL hold asynchronously.
REQ-033 When reset=1, D[i] SHALL be 2*(i+1), so ch0 = /2, ch1 = /4, ch2 = /6 and ch3 = /8.
REQ-034 cfg_ready SHALL be 1 after reset.
REQ-035 Reset asserted mid-period or with writes pending SHALL discard all pending writes.

Verification
REQ-036 The bench SHALL cover: reset released, en=4'b1111 -> clk_out[0] toggles each cycle; clk_out[1] is 0,0,1,1 repeating; tick[3] pulses every 8 cycles.
REQ-037 The bench SHALL cover: write ch1 D=5 mid-period -> cfg_ready for ch1 drops; old /4 period completes; then 5-cycle periods with high time 3; cfg_ready returns.
REQ-038 The bench SHALL cover: writes with cfg_div=1 and cfg_div=0 -> cfg_err pulses one cycle each; D[ch] unchanged; no pending set.
REQ-039 The bench SHALL cover: write ch2 on the exact wrap edge -> the current period stays /6, and the new divisor starts one full period later.
REQ-040 The bench SHALL cover: sync_rst pulse with channels at arbitrary phases -> next cycle all cnt=0 and all clk_out=0; subsequent ticks are aligned at common multiples.
REQ-041 The bench SHALL cover: reset asserted mid-period with pending writes -> outputs go to 0 without waiting for a clock edge; divisors return to 2, 4, 6, 8.
